serial_eight_bit_subtractor: RTL and testbench
==============================================

SERIAL_EIGHT_BIT_SUBTRACTOR -- requirements
Module: serial_eight_bit_subtractor

Interface
REQ-001 SHALL: clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL: start  input  1  request; sampled only in IDLE.
REQ-004 SHALL: x  input  8  minuend, unsigned; captured on accepted start.
REQ-005 SHALL: y  input  8  subtrahend, unsigned; captured on accepted start.
REQ-006 SHALL: borrow_in  input  1  borrow into bit 0; captured on accepted start.
REQ-007 SHALL: busy  output  1  high while an operation is in progress.
REQ-008 SHALL: done  output  1  one-cycle pulse marking a valid result.
REQ-009 SHALL: diff  output  8  result, registered, held until next completion.
REQ-010 SHALL: borrow_out  output  1  borrow out of bit 7, registered, held with diff.

Function
REQ-011 SHALL: FSM states are IDLE and BUSY only; done is a registered flag, not a state.
REQ-012 SHALL: IDLE + start=1 at edge E0 -> load x, y and borrow_in into the operand shift registers, clear the bit counter, and go to BUSY; busy=1 after E0.
REQ-013 SHALL: BUSY processes one bit per edge, LSB first, at edges E1..E8: d = a^b^br, br' = (~a&b) | (~(a^b)&br).
REQ-014 SHALL: the 3-bit counter runs 0..7; at E8 (count=7) update diff and borrow_out, set done=1, set busy=0, and return to IDLE.
REQ-015 SHALL: latency is fixed: done is high during the cycle following the 9th rising edge after the start edge (E0 counts as the first).
REQ-016 SHALL: done deasserts at E9 regardless of start.
REQ-017 SHALL: start while BUSY is ignored; operands captured at E0 are unaffected by later changes on x, y or borrow_in.
REQ-018 SHALL: start=1 during the done cycle is accepted at E9 (back-to-back): busy=1 and done=0 after E9.
REQ-019 SHALL: diff and borrow_out change only at completion edges; they do not change when a new operation starts.
REQ-020 SHALL: arithmetic result is {borrow_out, diff} = x - y - borrow_in, modulo 512; borrow_out=1 iff x < y + borrow_in.
REQ-021 SHALL: the partial result is held in an internal shift register; diff does not expose it mid-operation.

Reset
REQ-022 SHALL: rst_n=0 immediately forces IDLE, busy=0, done=0, diff=8'd0, borrow_out=0, and clears the counter and shift registers.
REQ-023 SHALL: reset during BUSY abandons the operation with no done pulse; the first start after rst_n releases behaves as REQ-012.

Configuration
REQ-024 SHALL: macro SERIAL_SUB_SAT_EN selects saturating mode.
- Defined: at completion, if the final borrow is 1 then diff=8'd0 (clamp); borrow_out still reports 1.
- Undefined: diff is the wrapped modulo-256 result per REQ-020.
- Latency, handshake and reset behaviour are identical in both modes.

Verification
REQ-025 SHALL: x=200, y=100, borrow_in=0, start at E0 -> done after E8, diff=100, borrow_out=0, busy low from E8.
REQ-026 SHALL: x=100, y=200, borrow_in=0 -> borrow_out=1; diff=156 without the macro, diff=0 with SERIAL_SUB_SAT_EN.
REQ-027 SHALL: x=0, y=0, borrow_in=1 -> diff=255 (0 when saturating), borrow_out=1; x=255, y=0, borrow_in=0 -> diff=255, borrow_out=0.
REQ-028 SHALL: start with x=50, y=20; at E3 pulse start with x=9, y=9 -> second start ignored; result diff=30, borrow_out=0, exactly one done pulse.
REQ-029 SHALL: assert rst_n=0 between E4 and E5 -> busy, done, diff and borrow_out go to 0 at once, no done pulse follows; a new start with x=7, y=3 yields diff=4 nine edges later.
REQ-030 SHALL: hold start=1 continuously with x=10, y=1 -> done pulses every 9 cycles, diff=9 each time, busy low only during done cycles.

Source files
------------

// File: rtl/serial_eight_bit_subtractor.sv
// Bit-serial 8-bit subtractor: {borrow_out, diff} = x - y - borrow_in, one bit per clock, LSB first.
// Define SERIAL_SUB_SAT_EN to clamp diff to zero whenever the final borrow is set.
module serial_eight_bit_subtractor (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       borrow_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] diff,
    output logic       borrow_out
);

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 3;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]    state, state_nxt;
    logic [W-1:0]  a_sr, a_nxt;
    logic [W-1:0]  b_sr, b_nxt;
    logic [W-1:0]  res_sr, res_nxt;
    logic          br, br_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [W-1:0]  diff_nxt;
    logic          borrow_out_nxt;
    logic          done_nxt;
    logic          busy_nxt;

    // Full-subtractor cell on the current LSBs.
    logic         bit_a, bit_b, bit_d, bit_br;
    logic [W-1:0] final_res;

    assign bit_a     = a_sr[0];
    assign bit_b     = b_sr[0];
    assign bit_d     = bit_a ^ bit_b ^ br;
    assign bit_br    = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br);
    assign final_res = {bit_d, res_sr[W-1:1]};

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            a_sr       <= a_nxt;
            b_sr       <= b_nxt;
            res_sr     <= res_nxt;
            br         <= br_nxt;
            cnt        <= cnt_nxt;
            diff       <= diff_nxt;
            borrow_out <= borrow_out_nxt;
            done       <= done_nxt;
            busy       <= busy_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt      = state;
        a_nxt          = a_sr;
        b_nxt          = b_sr;
        res_nxt        = res_sr;
        br_nxt         = br;
        cnt_nxt        = cnt;
        diff_nxt       = diff;
        borrow_out_nxt = borrow_out;
        done_nxt       = 1'b0;
        busy_nxt       = busy;

        case (state)
            IDLE: begin
                if (start) begin
                    a_nxt     = x;
                    b_nxt     = y;
                    br_nxt    = borrow_in;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                a_nxt   = {1'b0, a_sr[W-1:1]};
                b_nxt   = {1'b0, b_sr[W-1:1]};
                res_nxt = final_res;
                br_nxt  = bit_br;
                cnt_nxt = cnt + CW'(1);
                if (cnt == CW'(W - 1)) begin
`ifdef SERIAL_SUB_SAT_EN
                    diff_nxt = bit_br ? '0 : final_res;
`else
                    diff_nxt = final_res;
`endif
                    borrow_out_nxt = bit_br;
                    done_nxt       = 1'b1;
                    busy_nxt       = 1'b0;
                    state_nxt      = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_eight_bit_subtractor.sv
// Self-checking bench for serial_eight_bit_subtractor: vector table, random ops vs. arithmetic model, corner sequences.
module tb_serial_eight_bit_subtractor;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] x;
    logic [7:0] y;
    logic       borrow_in;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow_out;

`ifdef SERIAL_SUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] prev_d = 8'd0;
    logic       prev_b = 1'b0;

    serial_eight_bit_subtractor dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .x          (x),
        .y          (y),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic       bi;
        logic [7:0] ed;
        logic       eb;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain 9-bit arithmetic, optional clamp.
    task automatic model(input logic [7:0] xa, input logic [7:0] ya, input logic bia,
                         output logic [7:0] ed, output logic eb);
        int r;
        r  = int'(xa) - int'(ya) - int'(bia);
        eb = (r < 0);
        ed = 8'(r + 512);
        if (SAT && eb) ed = 8'd0;
    endtask

    // One complete operation; pulse_edge>0 re-asserts start (with junk operands) sampled at that edge.
    task automatic run_op(input logic [7:0] xa, input logic [7:0] ya, input logic bia,
                          input logic [7:0] ed, input logic eb, input int pulse_edge, input string tag);
        bit bad_lat;
        bit bad_hold;
        @(negedge clk);
        x = xa; y = ya; borrow_in = bia; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, " busy after start"}, int'(busy), 1);
        check({tag, " diff held at start"}, int'({borrow_out, diff}), int'({prev_b, prev_d}));
        bad_lat  = 1'b0;
        bad_hold = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            @(posedge clk); #1;
            if (done || !busy) bad_lat = 1'b1;
            if (diff != prev_d || borrow_out != prev_b) bad_hold = 1'b1;
            x = 8'($urandom); y = 8'($urandom); borrow_in = 1'($urandom);
            start = (pulse_edge > 0) && (i == pulse_edge - 1);
            if (start) begin x = 8'd9; y = 8'd9; end
        end
        start = 1'b0;
        check({tag, " busy/done during op"}, int'(bad_lat), 0);
        check({tag, " diff hidden during op"}, int'(bad_hold), 0);
        @(posedge clk); #1;
        check({tag, " done at E8"}, int'(done), 1);
        check({tag, " busy at E8"}, int'(busy), 0);
        check({tag, " diff"}, int'(diff), int'(ed));
        check({tag, " borrow_out"}, int'(borrow_out), int'(eb));
        prev_d = ed;
        prev_b = eb;
        @(posedge clk); #1;
        check({tag, " done cleared E9"}, int'(done), 0);
    endtask

    initial begin
        vec_t vecs[6];
        logic [7:0] md;
        logic       mb;
        logic [7:0] rx, ry;
        logic       rb;
        int         ndone;

        vecs[0] = '{8'd200, 8'd100, 1'b0, 8'd100, 1'b0};
        vecs[1] = '{8'd100, 8'd200, 1'b0, SAT ? 8'd0 : 8'd156, 1'b1};
        vecs[2] = '{8'd0,   8'd0,   1'b1, SAT ? 8'd0 : 8'd255, 1'b1};
        vecs[3] = '{8'd255, 8'd0,   1'b0, 8'd255, 1'b0};
        vecs[4] = '{8'd0,   8'd255, 1'b0, SAT ? 8'd0 : 8'd1, 1'b1};
        vecs[5] = '{8'd128, 8'd127, 1'b1, 8'd0, 1'b0};

        rst_n = 1'b0; start = 1'b0; x = '0; y = '0; borrow_in = 1'b0;
        #12;
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset result", int'({borrow_out, diff}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++)
            run_op(vecs[i].x, vecs[i].y, vecs[i].bi, vecs[i].ed, vecs[i].eb, 0, $sformatf("vec%0d", i));

        for (int i = 0; i < 24; i++) begin
            rx = 8'($urandom); ry = 8'($urandom); rb = 1'($urandom);
            model(rx, ry, rb, md, mb);
            run_op(rx, ry, rb, md, mb, 0, $sformatf("rand%0d", i));
        end

        // Start while busy is ignored; exactly one done pulse.
        run_op(8'd50, 8'd20, 1'b0, 8'd30, 1'b0, 3, "ignore_start");
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        check("ignore_start extra activity", ndone, 0);

        // Reset mid-operation abandons it.
        @(negedge clk);
        x = 8'd3; y = 8'd1; borrow_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset busy", int'(busy), 0);
        check("midreset done", int'(done), 0);
        check("midreset result", int'({borrow_out, diff}), 0);
        prev_d = 8'd0;
        prev_b = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        check("midreset no done", ndone, 0);
        run_op(8'd7, 8'd3, 1'b0, 8'd4, 1'b0, 0, "after_reset");

        // Continuous start: back-to-back operations every 9 cycles.
        @(negedge clk);
        x = 8'd10; y = 8'd1; borrow_in = 1'b0; start = 1'b1;
        for (int k = 0; k < 27; k++) begin
            @(posedge clk); #1;
            check($sformatf("b2b done k%0d", k), int'(done), int'(k % 9 == 8));
            check($sformatf("b2b busy k%0d", k), int'(busy), int'(k % 9 != 8));
            if (k % 9 == 8) check($sformatf("b2b diff k%0d", k), int'({borrow_out, diff}), 9);
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check("b2b stop busy", int'(busy), 0);
        check("b2b stop done", int'(done), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
